// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - K=3 rate-1/2 (7,5) convolutional encoder and hard-decision register-exchange Viterbi decoder
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  // Hamming distance between the symbol expected on branch p --b--> and the received symbol.
  function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic b, input logic [1:0] rx);
    logic [1:0] diff;
    diff = {b ^ p[1] ^ p[0], b ^ p[0]} ^ rx;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Metric add that clamps at the top of the PM_W range instead of wrapping.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  logic [1:0]          enc_s;
  logic [PM_W-1:0]     pm      [4];
  logic [PM_W-1:0]     pm_next [4];
  logic [PM_W-1:0]     pm_norm [4];
  logic [TB_DEPTH-1:0] sr      [4];
  logic [TB_DEPTH-1:0] sr_next [4];
  logic [CNT_W-1:0]    sym_cnt;
  logic [1:0]          best;
  logic [PM_W-1:0]     pm_min;

  // Encoder: shift the new bit into {s1,s0} and emit {g0,g1} one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_s       <= 2'b00;
      enc_d_o     <= 2'b00;
      enc_valid_o <= 1'b0;
    end else if (enc_enable_i) begin
      enc_d_o     <= {enc_d_i ^ enc_s[1] ^ enc_s[0], enc_d_i ^ enc_s[0]};
      enc_valid_o <= 1'b1;
      enc_s       <= {enc_d_i, enc_s[1]};
    end else begin
      enc_d_o     <= 2'b00;
      enc_valid_o <= 1'b0;
    end
  end

  // Add-compare-select for all four states, then pick the best state and normalise metrics to min 0.
  always_comb begin
    logic [1:0]      st;
    logic [1:0]      pa;
    logic [1:0]      pb;
    logic [PM_W-1:0] ca;
    logic [PM_W-1:0] cb;
    st     = 2'b00;
    pa     = 2'b00;
    pb     = 2'b00;
    ca     = '0;
    cb     = '0;
    best   = 2'b00;
    pm_min = '0;
    for (int n = 0; n < 4; n++) begin
      pm_next[n] = '0;
      sr_next[n] = '0;
      pm_norm[n] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      st = 2'(n);
      pa = {st[0], 1'b0};
      pb = {st[0], 1'b1};
      ca = sat_add(pm[pa], branch_metric(pa, st[1], dec_d_i));
      cb = sat_add(pm[pb], branch_metric(pb, st[1], dec_d_i));
      // Ties keep the predecessor whose oldest bit is 0.
      if (cb < ca) begin
        pm_next[n] = cb;
        sr_next[n] = {sr[pb][TB_DEPTH-2:0], st[1]};
      end else begin
        pm_next[n] = ca;
        sr_next[n] = {sr[pa][TB_DEPTH-2:0], st[1]};
      end
    end
    pm_min = pm_next[0];
    for (int n = 1; n < 4; n++) begin
      if (pm_next[n] < pm_min) begin
        pm_min = pm_next[n];
        best   = 2'(n);
      end
    end
    for (int n = 0; n < 4; n++) begin
      pm_norm[n] = pm_next[n] - pm_min;
    end
  end

  // Decoder state: metrics, survivors, fill counter and the registered decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0]       <= '0;
      pm[1]       <= PM_W'(4);
      pm[2]       <= PM_W'(4);
      pm[3]       <= PM_W'(4);
      for (int n = 0; n < 4; n++) begin
        sr[n] <= '0;
      end
      sym_cnt     <= '0;
      dec_valid_o <= 1'b0;
      dec_d_o     <= 1'b0;
    end else if (dec_enable_i) begin
      for (int n = 0; n < 4; n++) begin
        pm[n] <= pm_norm[n];
        sr[n] <= sr_next[n];
      end
      if (sym_cnt != CNT_FULL) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
      if (sym_cnt >= CNT_LAST) begin
        dec_valid_o <= 1'b1;
      end
      dec_d_o <= sr_next[best][TB_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - randomized self-checking bench for viterbi_codec against a trellis reference model
module tb_viterbi_codec;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_valid_o;
  logic       dec_d_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: encoder history, per-state metric and full decoded path.
  bit         ebits[$];
  int         m_pm[4];
  bit         m_path[4][512];
  bit         n_path[4][512];
  int         m_len;
  logic       e_valid;
  logic [1:0] e_sym;
  logic       d_valid;
  logic       d_bit;
  bit         data[0:511];

  always #5 clk = ~clk;

  viterbi_codec #(.TB_DEPTH(D), .PM_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Generators 7 and 5: g0 = d ^ d[-1] ^ d[-2], g1 = d ^ d[-2].
  function automatic logic [1:0] enc_sym(input bit b, input bit prev1, input bit prev2);
    return {b ^ prev1 ^ prev2, b ^ prev2};
  endfunction

  task automatic model_reset();
    ebits.delete();
    m_pm = '{0, 4, 4, 4};
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 512; i++) m_path[n][i] = 1'b0;
    m_len   = 0;
    e_valid = 1'b0;
    e_sym   = 2'b00;
    d_valid = 1'b0;
    d_bit   = 1'b0;
  endtask

  task automatic model_step(input bit ee, input bit ed, input bit de, input logic [1:0] ds);
    int npm[4];
    int from[4];
    int c, n, mn, best, sz, bm;
    logic [1:0] x;
    if (ee) begin
      sz = ebits.size();
      e_sym = enc_sym(ed, sz >= 1 ? ebits[sz-1] : 1'b0, sz >= 2 ? ebits[sz-2] : 1'b0);
      ebits.push_back(ed);
      e_valid = 1'b1;
    end else begin
      e_sym   = 2'b00;
      e_valid = 1'b0;
    end
    if (de) begin
      for (int i = 0; i < 4; i++) begin
        npm[i]  = 1 << 30;
        from[i] = 0;
      end
      // Forward trellis walk: state p = {newest, older} bit; lower p wins ties.
      for (int p = 0; p < 4; p++) begin
        for (int b = 0; b < 2; b++) begin
          x  = enc_sym(bit'(b), bit'(p >> 1), bit'(p)) ^ ds;
          bm = int'(x[0]) + int'(x[1]);
          c  = m_pm[p] + bm;
          if (c > 255) c = 255;
          n = b * 2 + (p >> 1);
          if (c < npm[n]) begin
            npm[n]  = c;
            from[n] = p;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_path[i] = m_path[from[i]];
        n_path[i][m_len] = bit'(i >> 1);
      end
      m_len++;
      mn = npm[0];
      best = 0;
      for (int i = 1; i < 4; i++) begin
        if (npm[i] < mn) begin
          mn = npm[i];
          best = i;
        end
      end
      for (int i = 0; i < 4; i++) m_pm[i] = npm[i] - mn;
      m_path  = n_path;
      d_valid = (m_len >= D);
      d_bit   = (m_len >= D) ? n_path[best][m_len-D] : 1'b0;
    end
  endtask

  task automatic cycle(input bit ee, input bit ed, input bit de, input logic [1:0] ds);
    enc_enable_i = ee;
    enc_d_i      = ed;
    dec_enable_i = de;
    dec_d_i      = ds;
    @(posedge clk);
    model_step(ee, ed, de, ds);
    #1;
    check("enc_valid", enc_valid_o, e_valid);
    check("enc_d", enc_d_o, e_sym);
    check("dec_valid", dec_valid_o, d_valid);
    check("dec_d", dec_d_o, d_bit);
  endtask

  task automatic do_reset();
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    rst = 1'b0;
    #1;
    check("rst_enc_valid", enc_valid_o, 0);
    check("rst_enc_d", enc_d_o, 0);
    check("rst_dec_valid", dec_valid_o, 0);
    check("rst_dec_d", dec_d_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fill_random(input int n, input int nflush);
    for (int i = 0; i < n; i++) data[i] = bit'($urandom_range(0, 1));
    for (int i = n; i < n + nflush; i++) data[i] = 1'b0;
  endtask

  task automatic run_stream(input int n, input int flip_at, input int burst, input logic [1:0] mask,
                            input bit gaps, input bit truth);
    int k, guard;
    bit en;
    logic [1:0] sym;
    k = 0;
    guard = 0;
    while (k < n) begin
      en  = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      sym = enc_sym(data[k], k >= 1 ? data[k-1] : 1'b0, k >= 2 ? data[k-2] : 1'b0);
      if (k >= flip_at && k < flip_at + burst) sym = sym ^ mask;
      cycle(en, data[k], en, sym);
      if (en) k++;
      if (truth && en && m_len >= D) check("truth", dec_d_o, data[m_len-D]);
      guard++;
      if (guard > 8 * n + 64) begin
        check("stream_budget", guard, 0);
        break;
      end
    end
  endtask

  initial begin
    logic [1:0] imp_exp[4];
    logic [6:0] head;
    imp_exp = '{2'b11, 2'b10, 2'b11, 2'b00};
    head    = 7'b1011001;

    #3;
    do_reset();

    // Encoder impulse response.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i == 0, 1'b0, 2'b00);
      check("impulse", enc_d_o, imp_exp[i]);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'b00);

    // Clean loop with zero flush.
    do_reset();
    fill_random(64, D);
    run_stream(64 + D, 1000, 0, 2'b00, 1'b0, 1'b1);

    // Single error on symbol 20.
    do_reset();
    fill_random(64, D);
    for (int i = 0; i < 7; i++) data[i] = head[6-i];
    run_stream(64 + D, 20, 1, 2'b01, 1'b0, 1'b1);

    // Random enable gaps.
    do_reset();
    fill_random(64, D);
    run_stream(64 + D, 1000, 0, 2'b00, 1'b1, 1'b1);

    // Reset mid-stream at symbol 30, then a fresh stream.
    do_reset();
    fill_random(64, D);
    run_stream(30, 1000, 0, 2'b00, 1'b0, 1'b1);
    do_reset();
    fill_random(40, D);
    run_stream(40 + D, 1000, 0, 2'b00, 1'b0, 1'b1);

    // Burst of three adjacent corrupted symbols, then idle cycles.
    do_reset();
    fill_random(64, D);
    run_stream(64 + D, 25, 3, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
